// File: rtl/uart_debug_bridge_pkg.sv
// rtl/uart_debug_bridge_pkg.sv - command/response codes and FSM states for the UART debug bridge
package uart_debug_bridge_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] RESP_OK      = 8'hAA;
    localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WDATA,
        ST_BUS,
        ST_RESP,
        ST_WAIT_TX
    } bridge_state_t;

endpackage

// File: rtl/bridge_timeout.sv
// rtl/bridge_timeout.sv - loadable saturating down-counter; expired while the count sits at zero
module bridge_timeout #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_debug_bridge.sv
// rtl/uart_debug_bridge.sv - byte-level read/write command responder between UART core and CSR bus
module uart_debug_bridge
    import uart_debug_bridge_pkg::*;
#(
    parameter int RX_TIMEOUT  = 1_000_000,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_stb,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        frame_err
);

    localparam int RX_W  = $clog2(RX_TIMEOUT + 1);
    localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);
    // Counters expire on the final allowed cycle, so they load with N-1.
    localparam logic [RX_W-1:0]  RX_LOAD  = RX_W'(RX_TIMEOUT - 1);
    localparam logic [BUS_W-1:0] BUS_LOAD = BUS_W'(BUS_TIMEOUT - 1);

    bridge_state_t state, state_n;
    logic [15:0]   addr_n;
    logic [7:0]    wdata_n;
    logic [7:0]    tx_data_n;
    logic          we_n;
    logic          stb_n;
    logic          tx_wr_n;
    logic          err_n;
    logic          rx_expired;
    logic          bus_expired;

    bridge_timeout #(.WIDTH(RX_W)) u_rx_timeout (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .load       (rx_done),
        .load_value (RX_LOAD),
        .expired    (rx_expired)
    );

    // Held at its load value outside BUS so it starts counting on the first bus cycle.
    bridge_timeout #(.WIDTH(BUS_W)) u_bus_timeout (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .load       (state != ST_BUS),
        .load_value (BUS_LOAD),
        .expired    (bus_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_stb   <= 1'b0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            bus_we    <= we_n;
            bus_stb   <= stb_n;
            tx_data   <= tx_data_n;
            tx_wr     <= tx_wr_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = bus_addr;
        wdata_n   = bus_wdata;
        we_n      = bus_we;
        stb_n     = 1'b0;
        tx_data_n = tx_data;
        tx_wr_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_WRITE) begin
                        we_n    = 1'b1;
                        state_n = ST_ADDR_HI;
                    end else if (rx_data == CMD_READ) begin
                        we_n    = 1'b0;
                        state_n = ST_ADDR_HI;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ADDR_HI: begin
                if (rx_done) begin
                    addr_n[15:8] = rx_data;
                    state_n      = ST_ADDR_LO;
                end else if (rx_expired) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_done) begin
                    addr_n[7:0] = rx_data;
                    if (bus_we) begin
                        state_n = ST_WDATA;
                    end else begin
                        stb_n   = 1'b1;
                        state_n = ST_BUS;
                    end
                end else if (rx_expired) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (rx_done) begin
                    wdata_n = rx_data;
                    stb_n   = 1'b1;
                    state_n = ST_BUS;
                end else if (rx_expired) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus_ack) begin
                    tx_data_n = bus_we ? RESP_OK : bus_rdata;
                    tx_wr_n   = 1'b1;
                    state_n   = ST_RESP;
                end else if (bus_expired) begin
                    tx_data_n = RESP_TIMEOUT;
                    tx_wr_n   = 1'b1;
                    err_n     = 1'b1;
                    state_n   = ST_RESP;
                end else begin
                    stb_n = 1'b1;
                end
            end
            ST_RESP: begin
                state_n = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// tb/tb_uart_debug_bridge.sv - directed self-checking bench for uart_debug_bridge
module tb_uart_debug_bridge;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done = 1'b0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_stb;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_rdata = 8'h00;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;
    int tx_count = 0;
    int snap;
    int n;

    always #5 sys_clk = ~sys_clk;

    uart_debug_bridge #(.RX_TIMEOUT(100), .BUS_TIMEOUT(255)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_stb   (bus_stb),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .frame_err (frame_err)
    );

    always @(negedge sys_clk) begin
        if (tx_wr) tx_count++;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
    endtask

    task automatic ack_bus(input logic [7:0] rdata);
        bus_rdata = rdata;
        bus_ack = 1'b1;
        @(negedge sys_clk);
        bus_ack = 1'b0;
    endtask

    task automatic finish_tx();
        repeat (3) @(negedge sys_clk);
        tx_done = 1'b1;
        @(negedge sys_clk);
        tx_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge sys_clk);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_bus_stb", bus_stb, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_tx_data", tx_data, 0);
        sys_rst_n = 1'b1;

        // write 01 12 34 5A
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
        check("wr_stb", bus_stb, 1);
        check("wr_addr", bus_addr, 32'h1234);
        check("wr_wdata", bus_wdata, 32'h5A);
        check("wr_we", bus_we, 1);
        @(negedge sys_clk);
        ack_bus(8'h00);
        check("wr_stb_fall", bus_stb, 0);
        check("wr_tx_wr", tx_wr, 1);
        check("wr_tx_data", tx_data, 32'hAA);
        // byte during WAIT_TX is dropped
        send_byte(8'h02);
        check("drop_no_stb", bus_stb, 0);
        finish_tx();

        // read 02 00 10, rdata C3
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        check("rd_stb", bus_stb, 1);
        check("rd_addr", bus_addr, 32'h0010);
        check("rd_we", bus_we, 0);
        ack_bus(8'hC3);
        check("rd_stb_fall", bus_stb, 0);
        check("rd_tx_wr", tx_wr, 1);
        check("rd_tx_data", tx_data, 32'hC3);
        check("rd_no_err", frame_err, 0);
        finish_tx();

        // bus timeout: stb high exactly 255 cycles
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
        n = 0;
        while (bus_stb && n < 400) begin
            n++;
            @(negedge sys_clk);
        end
        check("to_stb_cycles", n, 255);
        check("to_tx_wr", tx_wr, 1);
        check("to_tx_data", tx_data, 32'hEE);
        check("to_frame_err", frame_err, 1);
        finish_tx();

        // ack coincident with timeout expiry: ack wins
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h30);
        repeat (254) @(negedge sys_clk);
        ack_bus(8'h3C);
        check("race_tx_wr", tx_wr, 1);
        check("race_tx_data", tx_data, 32'h3C);
        check("race_no_err", frame_err, 0);
        finish_tx();

        // unknown command
        snap = tx_count;
        send_byte(8'h7F);
        check("bad_cmd_err", frame_err, 1);
        repeat (5) @(negedge sys_clk);
        check("bad_cmd_no_tx", tx_count, snap);

        // partial frame abandoned after 100 idle cycles
        send_byte(8'h01); send_byte(8'h12);
        n = 0;
        while (!frame_err && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("rx_to_cycles", n, 100);
        check("rx_to_no_tx", tx_count, snap);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        check("after_to_addr", bus_addr, 32'h0000);
        check("after_to_stb", bus_stb, 1);
        ack_bus(8'h5C);
        check("after_to_tx_data", tx_data, 32'h5C);
        finish_tx();

        // reset while bus_stb is high
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h77);
        check("rst_mid_stb_before", bus_stb, 1);
        snap = tx_count;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_stb_async", bus_stb, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("rst_mid_no_tx", tx_count, snap);
        check("rst_mid_stb_idle", bus_stb, 0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h40);
        check("rst_mid_next_addr", bus_addr, 32'h0040);
        ack_bus(8'h81);
        check("rst_mid_next_tx", tx_data, 32'h81);
        finish_tx();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
